// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_pkg
// Brief    : Shared fetch-stage widths, NOP word and fetch state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

   // PC / ROM address width (256-word program space)
   localparam int C_ADDR_W  = 8;
   // Instruction word width
   localparam int C_INSTR_W = 32;
   // Bubble word presented to execute when instr_valid is low
   localparam logic [31:0] C_NOP = 32'd0;

   // Fetch sequencer states; FETCH_HALT is only reachable with breakpoints built in
   typedef enum logic [1:0] {
      FETCH_FLUSH = 2'd0,
      FETCH_RUN   = 2'd1,
      FETCH_HALT  = 2'd2
   } fetch_state_t;

endpackage : instruction_fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_program_counter.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_program_counter
// Brief    : PC register: +1 with natural wrap, load of a redirect target,
//            hold whenever the step tick is low or no fetch is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_program_counter #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_enable,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_addr,
   input  logic              i_advance,
   output logic [ADDR_W-1:0] o_pc
);

   logic [ADDR_W-1:0] r_pc;

   // Redirect beats increment; the increment wraps silently at the top of the ROM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= '0;
      end else if (i_enable) begin
         if (i_load) begin
            r_pc <= i_load_addr;
         end else if (i_advance) begin
            r_pc <= r_pc + ADDR_W'(1);
         end
      end
   end

   assign o_pc = r_pc;

endmodule : instruction_fetch_program_counter
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Fetch stage. Drives the PC as the ROM address, registers the
//            returned word for execute, redirects on taken JMP/ATC and holds
//            during stalls. Optional macro FETCH_BREAKPOINT_EN adds a PC
//            breakpoint with HALT state, resume pulse and halted flag.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int ADDR_W  = C_ADDR_W,
   parameter int INSTR_W = C_INSTR_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               stall,
   input  logic               jump_taken,
   input  logic [ADDR_W-1:0]  jump_addr,
   output logic [ADDR_W-1:0]  mem_address,
   input  logic [INSTR_W-1:0] mem_instruction,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid
`ifdef FETCH_BREAKPOINT_EN
   ,
   input  logic               break_en,
   input  logic [ADDR_W-1:0]  break_addr,
   input  logic               resume,
   output logic               halted
`endif
);

   localparam logic [INSTR_W-1:0] c_bubble = INSTR_W'(C_NOP);

   fetch_state_t       r_state;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_instr_pc;
   logic               r_instr_valid;
   logic [ADDR_W-1:0]  w_pc;
   logic               w_in_halt;
   logic               w_break_hit;
   logic               w_advance;

`ifdef FETCH_BREAKPOINT_EN
   logic r_halted;
   logic r_skip_once;

   // skip_once lets the word at the breakpoint through exactly once after a resume
   assign w_break_hit = break_en && (w_pc == break_addr) && !r_skip_once;
   assign halted      = r_halted;
`else
   assign w_break_hit = 1'b0;
`endif

   assign w_in_halt = (r_state == FETCH_HALT);
   // A fetch is accepted only when nothing of higher priority claims the cycle
   assign w_advance = !jump_taken && !stall && !w_in_halt && !w_break_hit;

   instruction_fetch_program_counter #(
      .ADDR_W (ADDR_W)
   ) u_program_counter (
      .clk         (clock),
      .rst         (reset),
      .i_enable    (enable),
      .i_load      (jump_taken),
      .i_load_addr (jump_addr),
      .i_advance   (w_advance),
      .o_pc        (w_pc)
   );

   // Fetch sequencer and instruction register: redirect > stall > halt > fetch
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= FETCH_FLUSH;
         r_instr       <= c_bubble;
         r_instr_pc    <= '0;
         r_instr_valid <= 1'b0;
`ifdef FETCH_BREAKPOINT_EN
         r_halted      <= 1'b0;
         r_skip_once   <= 1'b0;
`endif
      end else if (enable) begin
         if (jump_taken) begin
            r_instr       <= c_bubble;
            r_instr_valid <= 1'b0;
            // A redirect while halted moves the PC but keeps the core halted
            if (!w_in_halt) begin
               r_state <= FETCH_FLUSH;
            end
         end else if (!stall) begin
            if (w_in_halt) begin
`ifdef FETCH_BREAKPOINT_EN
               if (resume) begin
                  r_state     <= FETCH_RUN;
                  r_halted    <= 1'b0;
                  r_skip_once <= 1'b1;
               end
`endif
            end else if (w_break_hit) begin
`ifdef FETCH_BREAKPOINT_EN
               r_state       <= FETCH_HALT;
               r_halted      <= 1'b1;
               r_instr       <= c_bubble;
               r_instr_valid <= 1'b0;
`endif
            end else begin
               r_state       <= FETCH_RUN;
               r_instr       <= mem_instruction;
               r_instr_pc    <= w_pc;
               r_instr_valid <= 1'b1;
`ifdef FETCH_BREAKPOINT_EN
               r_skip_once   <= 1'b0;
`endif
            end
         end
      end
   end

   assign mem_address = w_pc;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_instr_valid;

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Self-checking bench for instruction_fetch: directed scenarios and
//            randomized traffic against a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

   logic        clock = 1'b0;
   logic        reset, enable, stall, jump_taken;
   logic [7:0]  jump_addr;
   logic [7:0]  mem_address;
   logic [31:0] mem_instruction;
   logic [31:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
`ifdef FETCH_BREAKPOINT_EN
   logic        break_en, resume, halted;
   logic [7:0]  break_addr;
`endif

   logic [31:0] rom [256];
   logic        rom_fixed;

   // Reference model state
   logic [7:0]  m_pc;
   logic [31:0] m_instr;
   logic [7:0]  m_instr_pc;
   logic        m_valid;
   logic        m_halted;
   logic        m_skip;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   assign mem_instruction = rom_fixed ? 32'hDEADBEEF : rom[mem_address];

   instruction_fetch dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .stall           (stall),
      .jump_taken      (jump_taken),
      .jump_addr       (jump_addr),
      .mem_address     (mem_address),
      .mem_instruction (mem_instruction),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .instr_valid     (instr_valid)
`ifdef FETCH_BREAKPOINT_EN
      ,
      .break_en        (break_en),
      .break_addr      (break_addr),
      .resume          (resume),
      .halted          (halted)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rom_word(input logic [7:0] a);
      return rom_fixed ? 32'hDEADBEEF : rom[a];
   endfunction

   // One clock of the fetch rules applied to the currently driven inputs
   task automatic model_step();
      logic brk;
      brk = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
      brk = break_en && (m_pc == break_addr) && !m_skip;
`endif
      if (reset) begin
         m_pc = 8'd0; m_instr = 32'd0; m_instr_pc = 8'd0;
         m_valid = 1'b0; m_halted = 1'b0; m_skip = 1'b0;
      end else if (enable) begin
         if (jump_taken) begin
            m_pc = jump_addr; m_instr = 32'd0; m_valid = 1'b0;
         end else if (stall) begin
            // everything holds
         end else if (m_halted) begin
`ifdef FETCH_BREAKPOINT_EN
            if (resume) begin
               m_halted = 1'b0; m_skip = 1'b1;
            end
`endif
         end else if (brk) begin
            m_halted = 1'b1; m_valid = 1'b0; m_instr = 32'd0;
         end else begin
            m_instr = rom_word(m_pc); m_instr_pc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 8'd1; m_skip = 1'b0;
         end
      end
   endtask

   task automatic check_all();
      check("mem_address", {24'd0, mem_address}, {24'd0, m_pc});
      check("instr", instr, m_instr);
      check("instr_pc", {24'd0, instr_pc}, {24'd0, m_instr_pc});
      check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
`ifdef FETCH_BREAKPOINT_EN
      check("halted", {31'd0, halted}, {31'd0, m_halted});
`endif
   endtask

   task automatic cycle();
      model_step();
      @(posedge clock);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      reset = 1'b1; enable = 1'b1; stall = 1'b0; jump_taken = 1'b0; jump_addr = 8'd0;
      rom_fixed = 1'b1;
      m_pc = 8'd0; m_instr = 32'd0; m_instr_pc = 8'd0; m_valid = 1'b0; m_halted = 1'b0; m_skip = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
      break_en = 1'b0; break_addr = 8'd0; resume = 1'b0;
`endif

      // T1: reset with a constant ROM, then the first fetch
      cycle();
      cycle();
      check("t1_rst_instr", instr, 32'd0);
      check("t1_rst_valid", {31'd0, instr_valid}, 32'd0);
      check("t1_rst_addr", {24'd0, mem_address}, 32'd0);
      reset = 1'b0;
      cycle();
      check("t1_first_instr", instr, 32'hDEADBEEF);
      check("t1_first_pc", {24'd0, instr_pc}, 32'd0);
      check("t1_first_addr", {24'd0, mem_address}, 32'd1);
      rom_fixed = 1'b0;

      // T2: free run across the address wrap
      do_reset();
      for (int k = 0; k < 258; k++) begin
         check("t2_addr", {24'd0, mem_address}, k % 256);
         cycle();
         check("t2_trail", {24'd0, instr_pc}, k % 256);
         check("t2_valid", {31'd0, instr_valid}, 32'd1);
      end
      check("t2_wrap_addr", {24'd0, mem_address}, 32'd2);

      // T3: taken jump from pc=3 to 36
      do_reset();
      repeat (3) cycle();
      check("t3_pre_addr", {24'd0, mem_address}, 32'd3);
      jump_taken = 1'b1; jump_addr = 8'd36;
      cycle();
      jump_taken = 1'b0;
      check("t3_bubble_instr", instr, 32'd0);
      check("t3_bubble_valid", {31'd0, instr_valid}, 32'd0);
      check("t3_target_addr", {24'd0, mem_address}, 32'd36);
      cycle();
      check("t3_target_instr", instr, rom[36]);
      check("t3_target_pc", {24'd0, instr_pc}, 32'd36);
      check("t3_next_addr", {24'd0, mem_address}, 32'd37);

      // T4: stall at pc=10 with a jump to 5 on the second stall cycle
      do_reset();
      repeat (10) cycle();
      stall = 1'b1;
      cycle();
      check("t4_stall_addr", {24'd0, mem_address}, 32'd10);
      check("t4_stall_pc", {24'd0, instr_pc}, 32'd9);
      jump_taken = 1'b1; jump_addr = 8'd5;
      cycle();
      jump_taken = 1'b0;
      check("t4_jump_valid", {31'd0, instr_valid}, 32'd0);
      check("t4_jump_addr", {24'd0, mem_address}, 32'd5);
      cycle();
      check("t4_hold_addr", {24'd0, mem_address}, 32'd5);
      stall = 1'b0;
      cycle();
      check("t4_target_pc", {24'd0, instr_pc}, 32'd5);
      check("t4_target_instr", instr, rom[5]);

      // T5: enable low blocks a jump; reset during a stall
      enable = 1'b0; jump_taken = 1'b1; jump_addr = 8'd99;
      repeat (4) cycle();
      check("t5_hold_addr", {24'd0, mem_address}, 32'd6);
      check("t5_hold_pc", {24'd0, instr_pc}, 32'd5);
      enable = 1'b1; jump_taken = 1'b0; stall = 1'b1; reset = 1'b1;
      cycle();
      check("t5_rst_addr", {24'd0, mem_address}, 32'd0);
      check("t5_rst_valid", {31'd0, instr_valid}, 32'd0);
      reset = 1'b0; stall = 1'b0;

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         reset      = ($urandom_range(0, 63) == 0);
         enable     = ($urandom_range(0, 3) != 0);
         stall      = ($urandom_range(0, 3) == 0);
         jump_taken = ($urandom_range(0, 7) == 0);
         jump_addr  = 8'($urandom);
`ifdef FETCH_BREAKPOINT_EN
         break_en   = ($urandom_range(0, 1) == 1);
         break_addr = 8'($urandom_range(0, 15));
         resume     = ($urandom_range(0, 7) == 0);
`endif
         cycle();
      end
      reset = 1'b0; enable = 1'b1; stall = 1'b0; jump_taken = 1'b0;

`ifdef FETCH_BREAKPOINT_EN
      // T6: breakpoint at 23, resume, no re-halt
      break_en = 1'b0; resume = 1'b0;
      do_reset();
      break_en = 1'b1; break_addr = 8'd23;
      repeat (30) cycle();
      check("t6_halted", {31'd0, halted}, 32'd1);
      check("t6_valid", {31'd0, instr_valid}, 32'd0);
      check("t6_addr", {24'd0, mem_address}, 32'd23);
      resume = 1'b1;
      cycle();
      resume = 1'b0;
      cycle();
      check("t6_resume_pc", {24'd0, instr_pc}, 32'd23);
      cycle();
      check("t6_next_pc", {24'd0, instr_pc}, 32'd24);
      check("t6_no_rehalt", {31'd0, halted}, 32'd0);
      break_en = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_instruction_fetch
`default_nettype wire
